// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - parallel PRBS generator and self-synchronising checker
module prbs_gen_chk #(
  parameter int PN         = 7,
  parameter int W          = 8,
  parameter int ERR_CNT_W  = 32,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_s_rst,
  input  logic                 i_gen_en,
  input  logic                 i_inj_err,
  output logic [W-1:0]         o_gen_data,
  output logic                 o_gen_vld,
  input  logic [W-1:0]         i_chk_data,
  input  logic                 i_chk_vld,
  input  logic                 i_cnt_clr,
  output logic                 o_lock,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  // Second feedback tap for each supported polynomial x^PN + x^T + 1.
  function automatic int tap_of(input int pn);
    case (pn)
      7:       return 6;
      9:       return 5;
      11:      return 9;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return 0;
    endcase
  endfunction

  localparam int T          = tap_of(PN);
  localparam int TI         = (T > 0) ? T - 1 : 0;
  localparam int HUNT_WORDS = (PN + W - 1) / W;
  localparam int HC_W       = $clog2(HUNT_WORDS + 1);
  localparam int VC_W       = $clog2(LOCK_CNT + 1);
  localparam int UC_W       = $clog2(UNLOCK_CNT + 1);
  localparam int PC_W       = $clog2(W + 1);
  localparam int SUM_W      = ((ERR_CNT_W > PC_W) ? ERR_CNT_W : PC_W) + 1;

  generate
    if (T == 0) begin : g_bad_pn
      $error("prbs_gen_chk: PN must be one of 7, 9, 11, 15, 23, 31");
    end
    if (W < 1 || W > 64) begin : g_bad_w
      $error("prbs_gen_chk: W must be in 1..64");
    end
    if (LOCK_CNT < 1 || UNLOCK_CNT < 1) begin : g_bad_cnt
      $error("prbs_gen_chk: LOCK_CNT and UNLOCK_CNT must be at least 1");
    end
  endgenerate

  typedef logic [PN-1:0] state_t;
  typedef logic [W-1:0]  word_t;
  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCK} chk_st_t;

  // W unrolled serial steps; the earliest produced bit lands in bit W-1.
  function automatic word_t prbs_word(input state_t s);
    state_t st;
    word_t  w;
    logic   b;
    st = s;
    w  = '0;
    for (int i = W - 1; i >= 0; i--) begin
      b    = st[PN-1] ^ st[TI];
      w[i] = b;
      st   = {st[PN-2:0], b};
    end
    return w;
  endfunction

  // LFSR state after W serial steps.
  function automatic state_t prbs_next(input state_t s);
    state_t st;
    logic   b;
    st = s;
    for (int i = 0; i < W; i++) begin
      b  = st[PN-1] ^ st[TI];
      st = {st[PN-2:0], b};
    end
    return st;
  endfunction

  // Shift received bits into the state, earliest (bit W-1) first.
  function automatic state_t load_bits(input state_t s, input word_t d);
    state_t st;
    st = s;
    for (int i = W - 1; i >= 0; i--) begin
      st = {st[PN-2:0], d[i]};
    end
    return st;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input word_t d);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) begin
      c = c + PC_W'(d[i]);
    end
    return c;
  endfunction

  state_t          gen_state;
  word_t           gen_word;
  state_t          gen_next;
  word_t           inj_mask;

  chk_st_t         fsm;
  state_t          chk_state;
  word_t           chk_pred;
  state_t          chk_step;
  state_t          chk_load;
  word_t           chk_diff;
  logic [PC_W-1:0] chk_pc;
  logic            lock_word;
  logic [HC_W-1:0] hunt_cnt;
  logic [VC_W-1:0] good_cnt;
  logic [UC_W-1:0] bad_run;

  logic [SUM_W-1:0]     cnt_base;
  logic [SUM_W-1:0]     cnt_sum;
  logic [ERR_CNT_W-1:0] cnt_next;

  assign gen_word  = prbs_word(gen_state);
  assign gen_next  = prbs_next(gen_state);
  assign chk_pred  = prbs_word(chk_state);
  assign chk_step  = prbs_next(chk_state);
  assign chk_load  = load_bits(chk_state, i_chk_data);
  assign chk_diff  = i_chk_data ^ chk_pred;
  assign chk_pc    = popcount(chk_diff);
  assign lock_word = i_chk_vld && (fsm == ST_LOCK);

  // Injection flips only the earliest bit of the word being registered.
  always_comb begin
    inj_mask       = '0;
    inj_mask[W-1]  = i_inj_err;
  end

  // Next error count: clear wins over history, then add this word's popcount and saturate.
  always_comb begin
    cnt_base = i_cnt_clr ? '0 : SUM_W'(o_err_cnt);
    cnt_sum  = cnt_base + (lock_word ? SUM_W'(chk_pc) : '0);
    cnt_next = (cnt_sum > SUM_W'({ERR_CNT_W{1'b1}})) ? '1 : cnt_sum[ERR_CNT_W-1:0];
  end

  // Generator: advance W bits per enabled cycle and register the word.
  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      gen_state  <= '1;
      o_gen_data <= '0;
      o_gen_vld  <= 1'b0;
    end else begin
      o_gen_vld <= i_gen_en;
      if (i_gen_en) begin
        gen_state  <= gen_next;
        o_gen_data <= gen_word ^ inj_mask;
      end
    end
  end

  // Checker: HUNT loads the state, VERIFY qualifies it, LOCK free-runs and counts errors.
  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      fsm       <= ST_HUNT;
      chk_state <= '1;
      hunt_cnt  <= '0;
      good_cnt  <= '0;
      bad_run   <= '0;
      o_lock    <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      o_err     <= 1'b0;
      o_err_cnt <= cnt_next;
      if (i_chk_vld) begin
        case (fsm)
          ST_HUNT: begin
            chk_state <= chk_load;
            if (hunt_cnt == HC_W'(HUNT_WORDS - 1)) begin
              hunt_cnt <= '0;
              good_cnt <= '0;
              fsm      <= ST_VERIFY;
            end else begin
              hunt_cnt <= hunt_cnt + 1'b1;
            end
          end
          ST_VERIFY: begin
            chk_state <= chk_load;
            if (chk_diff != '0) begin
              hunt_cnt <= '0;
              fsm      <= ST_HUNT;
            end else if (good_cnt == VC_W'(LOCK_CNT - 1)) begin
              bad_run <= '0;
              o_lock  <= 1'b1;
              fsm     <= ST_LOCK;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
          ST_LOCK: begin
            chk_state <= chk_step;
            if (chk_diff != '0) begin
              o_err <= 1'b1;
              if (bad_run == UC_W'(UNLOCK_CNT - 1)) begin
                hunt_cnt <= '0;
                o_lock   <= 1'b0;
                fsm      <= ST_HUNT;
              end else begin
                bad_run <= bad_run + 1'b1;
              end
            end else begin
              bad_run <= '0;
            end
          end
          default: begin
            hunt_cnt <= '0;
            o_lock   <= 1'b0;
            fsm      <= ST_HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb/tb_prbs_gen_chk.sv - directed bench for prbs_gen_chk in loopback
module tb_prbs_gen_chk;

  logic clk = 1'b0;
  logic rst;
  logic gen_en;
  logic inj_a, inj_b, inv_a, clr_b;
  logic en_c, en_d;

  logic [7:0]  a_gen_data, a_chk_data;
  logic        a_gen_vld, a_lock, a_err;
  logic [31:0] a_cnt;

  logic [7:0]  b_gen_data;
  logic        b_gen_vld, b_lock, b_err;
  logic [3:0]  b_cnt;

  logic [0:0]  c_gen_data;
  logic        c_gen_vld, c_lock, c_err;
  logic [31:0] c_cnt;

  logic [63:0] d_gen_data;
  logic        d_gen_vld, d_lock, d_err;
  logic [31:0] d_cnt;

  int total = 0;
  int bad = 0;
  int widx = 0;
  int a_pulses = 0;
  int cnt_c = 0;
  int cnt_d = 0;
  bit done_c = 1'b0;
  bit done_d = 1'b0;
  bit seq [0:126];

  always #5 clk = ~clk;

  assign a_chk_data = a_gen_data ^ {8{inv_a}};

  prbs_gen_chk #(.PN(7), .W(8), .ERR_CNT_W(32), .LOCK_CNT(16), .UNLOCK_CNT(4)) u_a (
    .i_clk(clk), .i_s_rst(rst), .i_gen_en(gen_en), .i_inj_err(inj_a),
    .o_gen_data(a_gen_data), .o_gen_vld(a_gen_vld),
    .i_chk_data(a_chk_data), .i_chk_vld(a_gen_vld), .i_cnt_clr(1'b0),
    .o_lock(a_lock), .o_err(a_err), .o_err_cnt(a_cnt)
  );

  prbs_gen_chk #(.PN(7), .W(8), .ERR_CNT_W(4), .LOCK_CNT(16), .UNLOCK_CNT(4)) u_b (
    .i_clk(clk), .i_s_rst(rst), .i_gen_en(gen_en), .i_inj_err(inj_b),
    .o_gen_data(b_gen_data), .o_gen_vld(b_gen_vld),
    .i_chk_data(b_gen_data), .i_chk_vld(b_gen_vld), .i_cnt_clr(clr_b),
    .o_lock(b_lock), .o_err(b_err), .o_err_cnt(b_cnt)
  );

  prbs_gen_chk #(.PN(31), .W(1), .ERR_CNT_W(32), .LOCK_CNT(16), .UNLOCK_CNT(4)) u_c (
    .i_clk(clk), .i_s_rst(rst), .i_gen_en(en_c), .i_inj_err(1'b0),
    .o_gen_data(c_gen_data), .o_gen_vld(c_gen_vld),
    .i_chk_data(c_gen_data), .i_chk_vld(c_gen_vld), .i_cnt_clr(1'b0),
    .o_lock(c_lock), .o_err(c_err), .o_err_cnt(c_cnt)
  );

  prbs_gen_chk #(.PN(31), .W(64), .ERR_CNT_W(32), .LOCK_CNT(16), .UNLOCK_CNT(4)) u_d (
    .i_clk(clk), .i_s_rst(rst), .i_gen_en(en_d), .i_inj_err(1'b0),
    .o_gen_data(d_gen_data), .o_gen_vld(d_gen_vld),
    .i_chk_data(d_gen_data), .i_chk_vld(d_gen_vld), .i_cnt_clr(1'b0),
    .o_lock(d_lock), .o_err(d_err), .o_err_cnt(d_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // PRBS7 word k (period 127 bits), earliest bit in bit 7.
  function automatic logic [7:0] mword(input int k);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[7-i] = seq[(8 * k + i) % 127];
    return w;
  endfunction

  task automatic tick();
    logic ge, vc, vd;
    ge = gen_en;
    vc = c_gen_vld;
    vd = d_gen_vld;
    @(posedge clk);
    #1;
    if (ge) widx++;
    if (a_err) a_pulses++;
    if (vc === 1'b1) begin
      cnt_c++;
      if (cnt_c == 46) check("c_nolock_46", c_lock, 1'b0);
      if (cnt_c == 47) begin check("c_lock_47", c_lock, 1'b1); done_c = 1'b1; end
    end
    if (vd === 1'b1) begin
      cnt_d++;
      if (cnt_d == 16) check("d_nolock_16", d_lock, 1'b0);
      if (cnt_d == 17) begin check("d_lock_17", d_lock, 1'b1); done_d = 1'b1; end
    end
    en_c = 1'($urandom_range(0, 1));
    en_d = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b1; gen_en = 1'b0; inj_a = 1'b0; inj_b = 1'b0;
    inv_a = 1'b0; clr_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    for (int n = 0; n < 127; n++)
      seq[n] = ((n < 7) ? 1'b1 : seq[n-7]) ^ ((n < 6) ? 1'b1 : seq[n-6]);

    repeat (3) tick();
    check("rst_gen_data", a_gen_data, 8'h00);
    check("rst_gen_vld", a_gen_vld, 1'b0);
    check("rst_lock", a_lock, 1'b0);
    check("rst_err", a_err, 1'b0);
    check("rst_cnt", a_cnt, 0);
    rst = 1'b0;

    gen_en = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      check("a_word", a_gen_data, mword(widx - 1));
      if (k == 1) begin
        check("a_first_word", a_gen_data, 8'h02);
        check("a_first_vld", a_gen_vld, 1'b1);
      end
      if (k == 2) check("a_second_word", a_gen_data, 8'h0C);
      if (k == 128) check("a_period", a_gen_data, 8'h02);
      if (k == 17) check("a_nolock_16", a_lock, 1'b0);
      if (k == 18) check("a_lock_17", a_lock, 1'b1);
    end

    a_pulses = 0;
    repeat (10000) tick();
    check("a_long_pulses", a_pulses, 0);
    check("a_long_cnt", a_cnt, 0);
    check("a_long_lock", a_lock, 1'b1);
    check("a_long_word", a_gen_data, mword(widx - 1));
    check("b_long_cnt", b_cnt, 4'h0);

    a_pulses = 0;
    inj_a = 1'b1; tick(); inj_a = 1'b0;
    check("a_inj_word", a_gen_data, mword(widx - 1) ^ 8'h80);
    repeat (5) tick();
    check("a_inj_pulses", a_pulses, 1);
    check("a_inj_cnt", a_cnt, 1);
    check("a_inj_lock", a_lock, 1'b1);

    gen_en = 1'b0; inj_a = 1'b1; tick();
    check("a_gap_vld", a_gen_vld, 1'b0);
    check("a_gap_hold", a_gen_data, mword(widx - 1));
    tick();
    inj_a = 1'b0; gen_en = 1'b1; tick();
    check("a_gap_resume", a_gen_data, mword(widx - 1));
    repeat (3) tick();
    check("a_gap_pulses", a_pulses, 1);
    check("a_gap_lock", a_lock, 1'b1);

    a_pulses = 0;
    inv_a = 1'b1;
    repeat (3) tick();
    check("a_lock_3bad", a_lock, 1'b1);
    tick();
    inv_a = 1'b0;
    check("a_unlock", a_lock, 1'b0);
    check("a_unlock_pulses", a_pulses, 4);
    check("a_unlock_cnt", a_cnt, 33);
    for (int j = 1; j <= 17; j++) begin
      tick();
      if (j == 16) check("a_relock_16", a_lock, 1'b0);
      if (j == 17) check("a_relock_17", a_lock, 1'b1);
    end
    check("a_relock_cnt", a_cnt, 33);

    for (int i = 0; i < 20; i++) begin
      inj_b = 1'b1; tick(); inj_b = 1'b0; tick();
      if (i == 4) check("b_cnt_5", b_cnt, 4'h5);
    end
    repeat (2) tick();
    check("b_saturate", b_cnt, 4'hF);
    check("b_lock", b_lock, 1'b1);
    inj_b = 1'b1; tick(); inj_b = 1'b0;
    clr_b = 1'b1; tick(); clr_b = 1'b0;
    check("b_clr_err", b_cnt, 4'h1);
    clr_b = 1'b1; tick(); clr_b = 1'b0;
    check("b_clr_only", b_cnt, 4'h0);

    check("c_reached", done_c, 1'b1);
    check("d_reached", done_d, 1'b1);
    check("c_err_cnt", c_cnt, 0);
    check("d_err_cnt", d_cnt, 0);

    rst = 1'b1; tick();
    check("midrst_a_lock", a_lock, 1'b0);
    check("midrst_c_lock", c_lock, 1'b0);
    check("midrst_d_lock", d_lock, 1'b0);
    check("midrst_a_cnt", a_cnt, 0);
    check("midrst_a_vld", a_gen_vld, 1'b0);
    check("midrst_a_data", a_gen_data, 8'h00);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
